stream_demux: RTL and testbench

Parametrised, registered 1-to-NUM_CH stream demultiplexer with valid/ready handshaking on the input and on every output channel. It supports unicast (one selected channel) and broadcast (all channels) transfers, holds the word in a one-entry output stage until every addressed consumer accepts it, and discards out-of-range selects with an error pulse. It sits between the multicycle core's data path and memory-mapped or peripheral consumers that may stall, where the plain combinational 4-way demux cannot hold data.

---
 rtl/stream_demux_pkg.sv | 12 +
 rtl/onehot_decoder.sv | 21 ++
 rtl/stream_demux.sv | 93 +++++++++
 tb/tb_stream_demux.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types for the stream demultiplexer: holding-stage state and drop counter width.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    UNI,
    BCAST
  } state_t;

  localparam int DROP_CNT_WIDTH = 8;

endpackage

// File: rtl/onehot_decoder.sv
// Binary select to one-hot decoder with an in-range flag for non power-of-two channel counts.
module onehot_decoder #(
  parameter int NUM_CH    = 4,
  parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [NUM_CH-1:0]    onehot,
  output logic                 in_range
);

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_WIDTH'(k)) onehot[k] = 1'b1;
    end
  end

  // Extra bit so NUM_CH itself is representable when it is a power of two.
  assign in_range = ({1'b0, sel} < (SEL_WIDTH + 1)'(NUM_CH));

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH stream demux with unicast/broadcast and a one-entry holding stage.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_CH     = 4,
  localparam int SEL_WIDTH  = $clog2(NUM_CH)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [SEL_WIDTH-1:0]               select_i,
  input  logic                               bcast_i,
  input  logic [DATA_WIDTH-1:0]              data_i,
  output logic [NUM_CH-1:0]                  valid_o,
  input  logic [NUM_CH-1:0]                  ready_i,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]  data_o,
  output logic                               err_o,
  output logic [DROP_CNT_WIDTH-1:0]          drop_count_o
);

  state_t                  state, state_nxt;
  logic [NUM_CH-1:0]       pending, pending_nxt;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic [NUM_CH-1:0]       sel_onehot;
  logic                    sel_in_range;
  logic                    done;
  logic                    accept;
  logic                    load;
  logic                    err_nxt;

  onehot_decoder #(
    .NUM_CH    (NUM_CH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_decoder (
    .sel      (select_i),
    .onehot   (sel_onehot),
    .in_range (sel_in_range)
  );

  // The stage frees up in the same cycle its last addressed consumer takes the word.
  assign done    = ~|(pending & ~ready_i);
  assign ready_o = (state == EMPTY) || done;
  assign accept  = valid_i && ready_o;
  assign valid_o = pending;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending & ~ready_i;
    err_nxt     = 1'b0;
    load        = 1'b0;
    if (state != EMPTY && done) state_nxt = EMPTY;
    if (accept) begin
      if (bcast_i) begin
        state_nxt   = BCAST;
        pending_nxt = '1;
        load        = 1'b1;
      end else if (sel_in_range) begin
        state_nxt   = UNI;
        pending_nxt = sel_onehot;
        load        = 1'b1;
      end else begin
        state_nxt   = EMPTY;
        err_nxt     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= EMPTY;
      pending      <= '0;
      hold_data    <= '0;
      err_o        <= 1'b0;
      drop_count_o <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      err_o   <= err_nxt;
      if (load) hold_data <= data_i;
      if (err_nxt && drop_count_o != '1) drop_count_o <= drop_count_o + 1'b1;
    end
  end

  // Channels not addressed by the held word read zero.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      data_o[k] = pending[k] ? hold_data : '0;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench: a 4-channel and a 3-channel demux against a per-channel pending-set model.
module tb_stream_demux;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             v4, bc4, r4o, err4;
  logic [1:0]       s4;
  logic [31:0]      d4;
  logic [3:0]       vo4, ri4;
  logic [3:0][31:0] do4;
  logic [7:0]       dc4;

  logic             v3, bc3, r3o, err3;
  logic [1:0]       s3;
  logic [31:0]      d3;
  logic [2:0]       vo3, ri3;
  logic [2:0][31:0] do3;
  logic [7:0]       dc3;

  stream_demux #(.DATA_WIDTH(32), .NUM_CH(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .valid_i(v4), .ready_o(r4o), .select_i(s4),
    .bcast_i(bc4), .data_i(d4), .valid_o(vo4), .ready_i(ri4), .data_o(do4),
    .err_o(err4), .drop_count_o(dc4)
  );

  stream_demux #(.DATA_WIDTH(32), .NUM_CH(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .valid_i(v3), .ready_o(r3o), .select_i(s3),
    .bcast_i(bc3), .data_i(d3), .valid_o(vo3), .ready_i(ri3), .data_o(do3),
    .err_o(err3), .drop_count_o(dc3)
  );

  // Model: set of channels still owed the held word, plus drop bookkeeping.
  bit          mpend[2][4];
  logic [31:0] mdata[2];
  bit          merr[2];
  int          mdrops[2];
  int          nch[2] = '{4, 3};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mready(input int d, input logic [3:0] rdy);
    bit ok = 1'b1;
    for (int k = 0; k < nch[d]; k++) if (mpend[d][k] && !rdy[k]) ok = 1'b0;
    return ok;
  endfunction

  function automatic void mclear(input int d);
    for (int k = 0; k < 4; k++) mpend[d][k] = 1'b0;
    mdata[d]  = '0;
    merr[d]   = 1'b0;
    mdrops[d] = 0;
  endfunction

  function automatic void mstep(input int d, input bit v, input int sel, input bit bc,
                                input logic [31:0] data, input logic [3:0] rdy);
    bit ok = mready(d, rdy);
    for (int k = 0; k < nch[d]; k++) if (mpend[d][k] && rdy[k]) mpend[d][k] = 1'b0;
    merr[d] = 1'b0;
    if (v && ok) begin
      if (bc) begin
        for (int k = 0; k < nch[d]; k++) mpend[d][k] = 1'b1;
        mdata[d] = data;
      end else if (sel < nch[d]) begin
        mpend[d][sel] = 1'b1;
        mdata[d] = data;
      end else begin
        merr[d] = 1'b1;
        if (mdrops[d] < 255) mdrops[d]++;
      end
    end
  endfunction

  task automatic checkOutput(input int d);
    logic [3:0]  ovalid, rdy, evalid;
    logic        ordy, oerr;
    logic [7:0]  odc;
    logic [31:0] odata;
    if (d == 0) begin
      ovalid = vo4; rdy = ri4; ordy = r4o; oerr = err4; odc = dc4;
    end else begin
      ovalid = {1'b0, vo3}; rdy = {1'b1, ri3}; ordy = r3o; oerr = err3; odc = dc3;
    end
    evalid = '0;
    for (int k = 0; k < nch[d]; k++) evalid[k] = mpend[d][k];
    chk($sformatf("dut%0d ready_o", d), {31'b0, ordy}, {31'b0, mready(d, rdy)});
    chk($sformatf("dut%0d valid_o", d), {28'b0, ovalid}, {28'b0, evalid});
    for (int k = 0; k < nch[d]; k++) begin
      odata = (d == 0) ? do4[k] : do3[k];
      chk($sformatf("dut%0d data_o[%0d]", d, k), odata, mpend[d][k] ? mdata[d] : 32'h0);
    end
    chk($sformatf("dut%0d err_o", d), {31'b0, oerr}, {31'b0, merr[d]});
    chk($sformatf("dut%0d drop_count_o", d), {24'b0, odc}, mdrops[d]);
  endtask

  // Drive one DUT for one cycle (the other idles, draining), check both, advance the model.
  task automatic applyStimulus(input int d, input bit v, input int sel, input bit bc,
                               input logic [31:0] data, input logic [3:0] rdy);
    v4 = 1'b0; s4 = '0; bc4 = 1'b0; d4 = '0; ri4 = 4'hF;
    v3 = 1'b0; s3 = '0; bc3 = 1'b0; d3 = '0; ri3 = 3'h7;
    if (d == 0) begin
      v4 = v; s4 = 2'(sel); bc4 = bc; d4 = data; ri4 = rdy;
    end else begin
      v3 = v; s3 = 2'(sel); bc3 = bc; d3 = data; ri3 = rdy[2:0];
    end
    #1;
    checkOutput(0);
    checkOutput(1);
    @(posedge clk);
    if (reset) begin
      mclear(0);
      mclear(1);
    end else begin
      mstep(0, v4, int'(s4), bc4, d4, ri4);
      mstep(1, v3, int'(s3), bc3, d3, {1'b1, ri3});
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    v4 = 1'b0; s4 = '0; bc4 = 1'b0; d4 = '0; ri4 = 4'hF;
    v3 = 1'b0; s3 = '0; bc3 = 1'b0; d3 = '0; ri3 = 3'h7;
    mclear(0);
    mclear(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h0, 4'hF);

    // Unicast to channel 2.
    applyStimulus(0, 1, 2, 0, 32'hDEADBEEF, 4'hF);
    chk("unicast valid_o", {28'b0, vo4}, 32'h4);
    chk("unicast data_o[2]", do4[2], 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 32'h0, 4'hF);

    // Channel 1 stalls three cycles; the waiting word loads on the completing cycle.
    applyStimulus(0, 1, 1, 0, 32'hA5A5_0001, 4'hF);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 3, 0, 32'hC0DE_0003, 4'b1101);
    applyStimulus(0, 1, 3, 0, 32'hC0DE_0003, 4'hF);
    chk("stall next word valid_o", {28'b0, vo4}, 32'h8);
    applyStimulus(0, 0, 0, 0, 32'h0, 4'hF);

    // Broadcast with per-channel ready raised on cycles 1,3,2,5.
    applyStimulus(0, 1, 0, 1, 32'h12345678, 4'h0);
    for (int c = 1; c <= 5; c++)
      applyStimulus(0, 0, 0, 0, 32'h0, {c >= 5, c >= 2, c >= 3, c >= 1});
    applyStimulus(0, 0, 0, 0, 32'h0, 4'hF);

    // Back-to-back rotating channels at full throughput.
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, i % 4, 0, $urandom, 4'hF);
    applyStimulus(0, 0, 0, 0, 32'h0, 4'hF);

    // Out-of-range select on the 3-channel instance.
    applyStimulus(1, 1, 3, 0, 32'hBAD0_0000, 4'hF);
    chk("drop err_o", {31'b0, err3}, 32'h1);
    chk("drop count", {24'b0, dc3}, 32'h1);
    chk("drop valid_o", {29'b0, vo3}, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 4'hF);
    applyStimulus(1, 1, 3, 1, 32'h0B0B_0B0B, 4'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 4'hF);
    applyStimulus(1, 1, 0, 0, 32'h1111_2222, 4'hF);
    applyStimulus(1, 1, 0, 0, 32'h3333_4444, 4'h0);
    applyStimulus(1, 1, 3, 0, 32'h5555_6666, 4'hF);
    applyStimulus(1, 0, 0, 0, 32'h0, 4'hF);
    for (int i = 0; i < 300; i++) applyStimulus(1, 1, 3, 0, $urandom, 4'hF);
    chk("drop count saturated", {24'b0, dc3}, 32'd255);
    applyStimulus(1, 0, 0, 0, 32'h0, 4'hF);

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0, $urandom, 4'($urandom));

    // Reset while a broadcast still has channels 2 and 3 pending.
    applyStimulus(0, 0, 0, 0, 32'h0, 4'hF);
    applyStimulus(0, 1, 0, 1, 32'hFEED_F00D, 4'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 4'b0011);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 32'h0, 4'h0);
    reset = 1'b0;
    chk("reset valid_o", {28'b0, vo4}, 32'h0);
    chk("reset data_o[3]", do4[3], 32'h0);
    chk("reset err_o", {31'b0, err4}, 32'h0);
    chk("reset ready_o", {31'b0, r4o}, 32'h1);
    applyStimulus(0, 0, 0, 0, 32'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
